// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Fetch stage feeding the instruction buffer. Holds the fetch PC,
//             issues one aligned 8-byte request at a time to instruction
//             memory and presents up to two instructions (with PCs) to the
//             buffer. Handles branch redirects, including discarding a stale
//             in-flight response, and throttles on instbuf_full.
//  Ports    :
//    clk, rst                 clock / synchronous active-high reset
//    imem_req, imem_addr      request strobe and 8-byte aligned address
//    imem_rvalid, imem_rdata* response (one per request, latency >= 1)
//    inst_out*, pc_out*       instruction packet towards the buffer
//    out_valid1, out_valid2   slot valids (slot 2 only with slot 1)
//    instbuf_full             buffer cannot accept a packet this cycle
//    branch_flag, branch_pc   redirect request and target (highest priority)
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  // instruction memory
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata1,
  input  logic [INST_W-1:0] imem_rdata2,
  // instruction buffer
  output logic [INST_W-1:0] inst_out1,
  output logic [INST_W-1:0] inst_out2,
  output logic [PC_W-1:0]   pc_out1,
  output logic [PC_W-1:0]   pc_out2,
  output logic              out_valid1,
  output logic              out_valid2,
  input  logic              instbuf_full,
  // redirect
  input  logic              branch_flag,
  input  logic [PC_W-1:0]   branch_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // ready to issue a request
    S_WAIT = 2'd1,  // request outstanding
    S_HOLD = 2'd2,  // packet presented to the buffer
    S_DROP = 2'd3   // outstanding response must be discarded
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst1_q, inst1_d;
  logic [INST_W-1:0]   inst2_q, inst2_d;
  logic [PC_W-1:0]     pcout1_q, pcout1_d;
  logic [PC_W-1:0]     pcout2_q, pcout2_d;
  logic                valid1_q, valid1_d;
  logic                valid2_q, valid2_d;

  logic                req;
  logic                transfer;
  logic [PC_W-4:0]     line_inc;
  logic [PC_W-1:0]     branch_tgt;
  logic                unused_bits;

  // Branch targets are word aligned; the low two bits are discarded.
  assign branch_tgt  = {branch_pc[PC_W-1:2], 2'b00};
  assign unused_bits = ^branch_pc[1:0];

  // Next 8-byte line; wraps to zero past the top of the address space.
  assign line_inc = pc_q[PC_W-1:3] + {{(PC_W-4){1'b0}}, 1'b1};

  assign req      = (state_q == S_IDLE) && !instbuf_full && !branch_flag && !rst;
  assign transfer = valid1_q && !instbuf_full && !branch_flag;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst1_d  = inst1_q;
    inst2_d  = inst2_q;
    pcout1_d = pcout1_q;
    pcout2_d = pcout2_q;
    valid1_d = valid1_q;
    valid2_d = valid2_q;

    if (branch_flag) begin
      pc_d = branch_tgt;
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        // A response in the branch cycle belongs to the old stream and is
        // simply not captured; otherwise one response is still owed.
        S_WAIT: state_d = imem_rvalid ? S_IDLE : S_DROP;
        S_HOLD: begin
          valid1_d = 1'b0;
          valid2_d = 1'b0;
          state_d  = S_IDLE;
        end
        S_DROP: state_d = imem_rvalid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!pc_q[2]) begin
              inst1_d  = imem_rdata1;
              pcout1_d = pc_q;
              inst2_d  = imem_rdata2;
              // pc is 8-byte aligned here, so +4 only sets bit 2
              pcout2_d = {pc_q[PC_W-1:3], 3'b100};
              valid1_d = 1'b1;
              valid2_d = 1'b1;
            end else begin
              // Entered mid-pair: only the upper word is on the path.
              inst1_d  = imem_rdata2;
              pcout1_d = pc_q;
              inst2_d  = '0;
              pcout2_d = '0;
              valid1_d = 1'b1;
              valid2_d = 1'b0;
            end
            pc_d    = {line_inc, 3'b000};
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          // Captured responses are held until the buffer takes them.
          if (transfer) begin
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      inst1_q  <= '0;
      inst2_q  <= '0;
      pcout1_q <= '0;
      pcout2_q <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst1_q  <= inst1_d;
      inst2_q  <= inst2_d;
      pcout1_q <= pcout1_d;
      pcout2_q <= pcout2_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = {pc_q[PC_W-1:3], 3'b000};
  assign inst_out1  = inst1_q;
  assign inst_out2  = inst2_q;
  assign pc_out1    = pcout1_q;
  assign pc_out2    = pcout2_q;
  assign out_valid1 = valid1_q;
  assign out_valid2 = valid2_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : Directed bench for inst_fetch with a latency-programmable
//             memory model and request/packet scoreboards.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata1, imem_rdata2;
  logic [31:0] inst_out1, inst_out2, pc_out1, pc_out2;
  logic        out_valid1, out_valid2;
  logic        instbuf_full;
  logic        branch_flag;
  logic [31:0] branch_pc;

  always #5 clk = ~clk;

  inst_fetch #(.PC_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
    .inst_out1(inst_out1), .inst_out2(inst_out2),
    .pc_out1(pc_out1), .pc_out2(pc_out2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .instbuf_full(instbuf_full),
    .branch_flag(branch_flag), .branch_pc(branch_pc)
  );

  typedef struct { int due; logic [31:0] addr; } rsp_t;
  typedef struct { logic [31:0] pc; logic v2; } pkt_t;

  rsp_t        pending[$];
  logic [31:0] exp_req_q[$];
  pkt_t        exp_pkt_q[$];

  int cyc = 0;
  int lat = 1;
  int n_req = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Memory contents: unique, address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic void chk(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endfunction

  function automatic void push_pkt(input logic [31:0] pc, input logic v2);
    pkt_t p;
    p.pc = pc;
    p.v2 = v2;
    exp_pkt_q.push_back(p);
  endfunction

  // One clock: snapshot DUT state mid-cycle, advance, score requests and
  // transfers seen in that cycle, then drive the memory response.
  task automatic tick();
    logic        req_s, xfer_s, v2_s;
    logic [31:0] a_s, i1_s, i2_s, p1_s, p2_s;
    pkt_t        p;
    rsp_t        r;
    @(negedge clk);
    req_s  = imem_req;
    a_s    = imem_addr;
    xfer_s = out_valid1 && !instbuf_full && !branch_flag && !rst;
    v2_s   = out_valid2;
    i1_s   = inst_out1;
    i2_s   = inst_out2;
    p1_s   = pc_out1;
    p2_s   = pc_out2;
    @(posedge clk);
    #1;
    cyc++;
    if (req_s) begin
      n_req++;
      chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
      if (exp_req_q.size() != 0) chk("req_addr", a_s, exp_req_q.pop_front());
      r.due  = cyc - 1 + lat;
      r.addr = a_s;
      pending.push_back(r);
    end
    if (xfer_s) begin
      chk("pkt_expected", 32'(exp_pkt_q.size() != 0), 32'd1);
      if (exp_pkt_q.size() != 0) begin
        p = exp_pkt_q.pop_front();
        chk("pkt_pc1", p1_s, p.pc);
        chk("pkt_inst1", i1_s, mem_word(p.pc));
        chk("pkt_valid2", 32'(v2_s), 32'(p.v2));
        if (p.v2) begin
          chk("pkt_pc2", p2_s, p.pc + 32'd4);
          chk("pkt_inst2", i2_s, mem_word(p.pc + 32'd4));
        end
      end
    end
    imem_rvalid = 1'b0;
    imem_rdata1 = 32'hDEAD_BEEF;
    imem_rdata2 = 32'hDEAD_BEEF;
    if (pending.size() != 0 && pending[0].due == cyc) begin
      r = pending.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata1 = mem_word(r.addr);
      imem_rdata2 = mem_word(r.addr + 32'd4);
    end
  endtask

  task automatic wait_reqs(input int target);
    int k = 0;
    while (n_req < target && k < 40) begin
      tick();
      k++;
    end
    chk("req_count", n_req, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instbuf_full = 1'b0; branch_flag = 1'b0; branch_pc = '0;
    imem_rvalid = 1'b0; imem_rdata1 = '0; imem_rdata2 = '0;

    // ---- reset state
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_valid2", 32'(out_valid2), 32'd0);
    chk("rst_inst1", inst_out1, 32'd0);
    chk("rst_pc1", pc_out1, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // ---- straight-line fetch, latency 1
    exp_req_q.push_back(32'h0);
    push_pkt(32'h0, 1'b1);
    exp_req_q.push_back(32'h8);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    wait_reqs(n_req + 2);
    instbuf_full = 1'b1;               // packet @0x8 captured and held
    tick();
    chk("hold8_valid", 32'(out_valid1), 32'd1);
    chk("hold8_pc", pc_out1, 32'h8);

    // ---- branch in HOLD, then branch in IDLE (last target wins)
    branch_flag = 1'b1; branch_pc = 32'hF0;
    tick();
    chk("hold_br_valid", 32'(out_valid1), 32'd0);
    branch_pc = 32'h107; instbuf_full = 1'b0;
    #1;
    chk("idle_br_noreq", 32'(imem_req), 32'd0);
    tick();
    branch_flag = 1'b0;
    exp_req_q.push_back(32'h100);
    push_pkt(32'h104, 1'b0);
    exp_req_q.push_back(32'h108);
    #1;
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    wait_reqs(n_req + 2);

    // ---- response while full: held stable for 5 cycles
    instbuf_full = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("full_valid1", 32'(out_valid1), 32'd1);
      chk("full_pc1", pc_out1, 32'h108);
      chk("full_inst1", inst_out1, mem_word(32'h108));
      chk("full_noreq", 32'(imem_req), 32'd0);
      tick();
    end
    push_pkt(32'h108, 1'b1);
    exp_req_q.push_back(32'h110);
    lat = 3;
    instbuf_full = 1'b0;
    #1;
    chk("unfull_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("after_xfer_req", 32'(imem_req), 32'd1);
    chk("after_xfer_addr", imem_addr, 32'h110);

    // ---- branch while WAIT, latency 3: stale response dropped
    tick();
    branch_flag = 1'b1; branch_pc = 32'h200;
    #1;
    chk("wait_br_noreq", 32'(imem_req), 32'd0);
    tick();
    branch_flag = 1'b0;
    #1;
    chk("drop_noreq0", 32'(imem_req), 32'd0);
    tick();
    chk("drop_noreq1", 32'(imem_req), 32'd0);
    exp_req_q.push_back(32'h200);
    tick();
    chk("drop_done_req", 32'(imem_req), 32'd1);
    chk("drop_done_addr", imem_addr, 32'h200);

    // ---- branch coincident with rvalid in WAIT
    repeat (3) tick();
    branch_flag = 1'b1; branch_pc = 32'h340;
    #1;
    chk("coinc_noreq", 32'(imem_req), 32'd0);
    tick();
    branch_flag = 1'b0;
    lat = 4;
    exp_req_q.push_back(32'h340);
    push_pkt(32'h340, 1'b1);
    exp_req_q.push_back(32'h348);
    #1;
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h340);
    chk("coinc_valid1", 32'(out_valid1), 32'd0);
    wait_reqs(n_req + 2);

    // ---- reset mid-WAIT; late response arrives in IDLE and is ignored
    rst = 1'b1;
    tick();
    rst = 1'b0; instbuf_full = 1'b1;
    #1;
    chk("rstw_valid1", 32'(out_valid1), 32'd0);
    chk("rstw_req", 32'(imem_req), 32'd0);
    chk("rstw_addr", imem_addr, 32'h0);
    repeat (3) tick();
    chk("late_valid1", 32'(out_valid1), 32'd0);
    chk("late_valid2", 32'(out_valid2), 32'd0);
    chk("late_addr", imem_addr, 32'h0);
    exp_req_q.push_back(32'h0);
    push_pkt(32'h0, 1'b1);
    exp_req_q.push_back(32'h8);
    instbuf_full = 1'b0;
    wait_reqs(n_req + 2);
    instbuf_full = 1'b1;
    repeat (8) tick();

    chk("req_q_drained", exp_req_q.size(), 32'd0);
    chk("pkt_q_drained", exp_pkt_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch stage directly upstream of the instruction buffer. Holds the fetch PC and issues one aligned 8-byte request at a time to instruction memory. Returns up to two instructions with their PCs into the buffer's inst_in1/inst_in2 and inst_pc1/inst_pc2 inputs. Handles branch redirects, including discarding stale in-flight responses, and throttles on instbuf_full.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (bits [1:0] must be 0)
PC_W, 32, PC / address width (matches PC_BUS)
INST_W, 32, instruction width (matches INST_BUS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  one-cycle request strobe to instruction memory
imem_addr  out  PC_W  request address, always {pc[PC_W-1:3],3'b000}
imem_rvalid  in  1  response valid; exactly one per request, latency >=1 cycle
imem_rdata1  in  INST_W  word at imem_addr
imem_rdata2  in  INST_W  word at imem_addr+4
inst_out1  out  INST_W  slot-1 instruction to buffer
inst_out2  out  INST_W  slot-2 instruction to buffer
pc_out1  out  PC_W  PC of slot 1
pc_out2  out  PC_W  PC of slot 2
out_valid1  out  1  slot 1 holds a valid instruction
out_valid2  out  1  slot 2 holds a valid instruction (only if out_valid1)
instbuf_full  in  1  buffer cannot accept a packet this cycle
branch_flag  in  1  redirect, highest priority
branch_pc  in  PC_W  redirect target; bits [1:0] forced to 0

Behaviour:
- State register, 2 bits: IDLE, WAIT (request outstanding), HOLD (packet presented to buffer), DROP (outstanding response to discard).
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, out_valid1=0, out_valid2=0.
  - inst_out*/pc_out* = 0.
  - imem_addr follows pc.
- Reset has priority over everything. Any imem_rvalid arriving in IDLE after reset is ignored.
- Transfer: occurs when out_valid1 && !instbuf_full && !branch_flag.
- imem_req is combinational: (state==IDLE) && !instbuf_full && !branch_flag && !rst.
  - IDLE --req--> WAIT.
- WAIT, rvalid, no branch:
  - Capture into output registers; go to HOLD.
  - If pc[2]==0:
    - inst_out1=rdata1, pc_out1=pc.
    - inst_out2=rdata2, pc_out2=pc+4.
    - valid1=valid2=1.
  - If pc[2]==1 (entry mid-pair):
    - inst_out1=rdata2, pc_out1=pc.
    - valid1=1, valid2=0.
  - pc <= {pc[PC_W-1:3]+1,3'b000}. Wraps to 0 past the top of the address space.
- HOLD: outputs stable until transfer; on transfer, out_valid*<=0 and state goes to IDLE.
- Latency: request at cycle t, response at t+L, packet valid at t+L+1, earliest next request at t+L+2.
- branch_flag, in any state (not reset): pc <= {branch_pc[PC_W-1:2],2'b00}. Then per state:
  - IDLE: no request that cycle; stay IDLE.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid the same cycle: discard the data; go to IDLE.
  - HOLD: out_valid*<=0, discard the packet; go to IDLE. The packet presented in the branch cycle is never counted as transferred.
  - DROP without rvalid: stay DROP, new pc retained.
  - DROP with rvalid: go to IDLE.
- DROP without branch:
  - On rvalid: discard; go to IDLE.
  - pc is not incremented by a dropped response.
- Back-to-back branches: the last target wins. Only one response is ever dropped per outstanding request.
- imem_rvalid in IDLE or HOLD is a protocol violation. It is ignored; state and outputs are unchanged.
- instbuf_full only gates new requests and transfers. A response arriving while full is still captured into HOLD and never lost.

Test Plan:
- Reset, then deassert with instbuf_full=0 and memory latency 1:
  - imem_req at the first cycle with addr 0x0.
  - Packet {rdata1@0x0, rdata2@0x4}, valid1=valid2=1.
  - Next addr 0x8.
- branch_pc=0x104 while IDLE:
  - Next request addr 0x100.
  - Packet slot1=word@0x104, pc_out1=0x104, valid2=0.
  - Following request 0x108.
- Branch to 0x200 while WAIT, memory latency 3:
  - State goes to DROP; the stale response is not output.
  - Next request addr 0x200; stale pc+8 never appears.
- Branch coincident with imem_rvalid in WAIT:
  - Data discarded; state IDLE.
  - Next request at the branch target.
- Response arrives while instbuf_full=1 for 5 cycles:
  - Packet held stable in HOLD; no imem_req.
  - Transfer on the first cycle full=0; request issued the following cycle.
- rst asserted mid-WAIT:
  - Outputs invalid; pc=RESET_PC; late rvalid ignored.
  - Fresh request to RESET_PC.
